// File: rtl/bcd_product_converter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_product_converter_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_t      : FSM state encoding (IDLE / SHIFT)
//   - BCD_DIGIT_W  : width of one packed BCD digit
//   - ADJ_THRESH   : digit value at or above which the +3 correction applies
//   - ADJ_ADD      : correction added before each shift
// ---------------------------------------------------------------------------
package bcd_product_converter_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;

endpackage

// File: rtl/bcd_product_converter_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more, so that the following left shift carries correctly
// into the next digit.
// Ports:
//   digit_i  in   4  current BCD digit
//   digit_o  out  4  corrected digit (never exceeds 4'd15 for legal inputs)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_product_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Legal digits are 0..9, so the largest corrected value is 12 and the
    // 4-bit add cannot carry out of the nibble.
    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/bcd_product_converter.sv
// ---------------------------------------------------------------------------
// bcd_product_converter
// Sequential binary-to-BCD converter (shift-and-add-3). Captures P on Start,
// performs one shift per clock for WIDTH clocks and then presents the packed
// BCD result with a one-cycle Done pulse.
// Parameters:
//   WIDTH   binary input width
//   DIGITS  number of BCD digits; 10**DIGITS must exceed 2**WIDTH-1
// Ports:
//   Clock   in   1          rising-edge clock
//   ResetN  in   1          asynchronous active-low reset
//   Start   in   1          conversion request, honoured only in IDLE
//   P       in   WIDTH      binary operand, latched on the accepting edge
//   Busy    out  1          high while a conversion is running
//   Done    out  1          one-cycle pulse, Bcd holds a new result
//   Bcd     out  4*DIGITS   packed BCD, digit 0 in Bcd[3:0]; held until next Done
// ---------------------------------------------------------------------------
module bcd_product_converter
    import bcd_product_converter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)
(
    input  logic                            Clock,
    input  logic                            ResetN,
    input  logic                            Start,
    input  logic [WIDTH-1:0]                P,
    output logic                            Busy,
    output logic                            Done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   Bcd
);

    localparam int                BW       = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  bin_q;
    logic [WIDTH-1:0]  bin_d;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_d;
    logic [BW-1:0]     bcdAdj;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [BW-1:0]     bcdOut_q;

    // Per-digit +3 correction of the current BCD accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcdAdj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One double-dabble step: the corrected accumulator and the binary
    // register shift left together, bin_q's MSB entering the BCD LSB.
    // The top bit shifted out of the accumulator is always zero because the
    // digit count covers the full input range.
    always_comb begin
        bcd_d = (bcdAdj << 1) | {{(BW-1){1'b0}}, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
    end

    // Control FSM with registered Busy/Done/Bcd. The terminal test uses the
    // pre-increment count so the final shifted value is captured on the
    // same edge that raises Done.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcdOut_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        bin_q   <= P;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bcdOut_q <= bcd_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Bcd  = bcdOut_q;

endmodule

// File: tb/tb_bcd_product_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_product_converter
// Directed bench for bcd_product_converter. Inputs change and outputs are
// sampled on the falling clock edge; cycle c=1 is the falling edge right
// after the rising edge that accepts Start.
// ---------------------------------------------------------------------------
module tb_bcd_product_converter;

    logic        Clock;
    logic        ResetN;
    logic        Start;
    logic [15:0] P;
    logic        Busy;
    logic        Done;
    logic [19:0] Bcd;

    int checks   = 0;
    int failures = 0;

    bcd_product_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Start  (Start),
        .P      (P),
        .Busy   (Busy),
        .Done   (Done),
        .Bcd    (Bcd)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Pulses Start for one cycle with operand p, then watches up to 40
    // cycles for Done. doneAt is -1 if Done never appeared.
    task automatic convert(input logic [15:0] p, output int doneAt, output int busyCnt);
        @(negedge Clock);
        Start   = 1'b1;
        P       = p;
        doneAt  = -1;
        busyCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (c == 1) Start = 1'b0;
            if (Busy) busyCnt++;
            if (Done) begin
                doneAt = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        Start  = 1'b0;
        P      = '0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({Busy, Done, Bcd} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got Busy=%b Done=%b Bcd=%h, want 0/0/00000", Busy, Done, Bcd);
        end
        ResetN = 1'b1;
    endtask

    task automatic test_zero();
        int doneAt, busyCnt;
        convert(16'd0, doneAt, busyCnt);
        checks++;
        if (doneAt !== 17) begin
            failures++;
            $display("[TB] FAIL zero_latency: got doneAt=%0d, want 17", doneAt);
        end
        checks++;
        if (busyCnt !== 16) begin
            failures++;
            $display("[TB] FAIL zero_busy: got %0d busy cycles, want 16", busyCnt);
        end
        checks++;
        if (Bcd !== 20'h00000) begin
            failures++;
            $display("[TB] FAIL zero_bcd: got %h, want 00000", Bcd);
        end
    endtask

    task automatic test_max();
        int doneAt, busyCnt;
        convert(16'd65535, doneAt, busyCnt);
        checks++;
        if (doneAt !== 17) begin
            failures++;
            $display("[TB] FAIL max_latency: got doneAt=%0d, want 17", doneAt);
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL max_busy_at_done: got %b, want 0", Busy);
        end
        checks++;
        if (Bcd !== 20'h65535) begin
            failures++;
            $display("[TB] FAIL max_bcd: got %h, want 65535", Bcd);
        end
    endtask

    task automatic test_values();
        int doneAt, busyCnt;
        convert(16'd65025, doneAt, busyCnt);
        checks++;
        if (Bcd !== 20'h65025 || doneAt !== 17) begin
            failures++;
            $display("[TB] FAIL val_65025: got Bcd=%h doneAt=%0d, want 65025 at 17", Bcd, doneAt);
        end
        convert(16'd9999, doneAt, busyCnt);
        checks++;
        if (Bcd !== 20'h09999 || doneAt !== 17) begin
            failures++;
            $display("[TB] FAIL val_9999: got Bcd=%h doneAt=%0d, want 09999 at 17", Bcd, doneAt);
        end
        @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || Bcd !== 20'h09999) begin
            failures++;
            $display("[TB] FAIL done_pulse_hold: got Done=%b Bcd=%h, want 0 and 09999", Done, Bcd);
        end
    endtask

    task automatic test_start_while_busy();
        int doneCnt = 0;
        int firstDone = -1;
        @(negedge Clock);
        Start = 1'b1;
        P     = 16'd1234;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (c == 1) Start = 1'b0;
            if (c == 5) begin
                Start = 1'b1;
                P     = 16'd4321;
            end
            if (c == 6) Start = 1'b0;
            if (Done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = c;
            end
        end
        checks++;
        if (doneCnt !== 1 || firstDone !== 17) begin
            failures++;
            $display("[TB] FAIL busy_start_done: got %0d Done pulses first at %0d, want 1 at 17", doneCnt, firstDone);
        end
        checks++;
        if (Bcd !== 20'h01234) begin
            failures++;
            $display("[TB] FAIL busy_start_bcd: got %h, want 01234", Bcd);
        end
    endtask

    task automatic test_back_to_back();
        int done1 = -1;
        int done2 = -1;
        logic [19:0] bcd1 = '0;
        @(negedge Clock);
        Start = 1'b1;
        P     = 16'd100;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clock);
            if (Done) begin
                if (done1 < 0) begin
                    done1 = c;
                    bcd1  = Bcd;
                    P     = 16'd200;
                end else begin
                    done2 = c;
                    Start = 1'b0;
                    break;
                end
            end
        end
        Start = 1'b0;
        checks++;
        if (bcd1 !== 20'h00100 || done1 !== 17) begin
            failures++;
            $display("[TB] FAIL b2b_first: got Bcd=%h at %0d, want 00100 at 17", bcd1, done1);
        end
        checks++;
        if (done2 - done1 !== 17) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles, want 17", done2 - done1);
        end
        checks++;
        if (Bcd !== 20'h00200) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h, want 00200", Bcd);
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_reset_abort();
        int doneCnt = 0;
        int doneAt, busyCnt;
        @(negedge Clock);
        Start = 1'b1;
        P     = 16'd777;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (c == 1) Start = 1'b0;
        end
        #2 ResetN = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Bcd} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL abort_async: got Busy=%b Done=%b Bcd=%h, want 0/0/00000", Busy, Done, Bcd);
        end
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (Done || Busy) doneCnt++;
        end
        checks++;
        if (doneCnt !== 0 || Bcd !== 20'h00000) begin
            failures++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles Bcd=%h, want 0 and 00000", doneCnt, Bcd);
        end
        convert(16'd42, doneAt, busyCnt);
        checks++;
        if (Bcd !== 20'h00042 || doneAt !== 17) begin
            failures++;
            $display("[TB] FAIL abort_recover: got Bcd=%h at %0d, want 00042 at 17", Bcd, doneAt);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_values();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
